// File: rtl/keyed_xor_cipher_pkg.sv
// Shared definitions for the keyed XOR cipher stage.
//   XOR_DEFAULT_WIDTH : default data/key word width
//   xor_word_t        : word type at the default width
package xor_cipher_pkg;

  localparam int XOR_DEFAULT_WIDTH = 8;

  typedef logic [XOR_DEFAULT_WIDTH-1:0] xor_word_t;

endpackage

// File: rtl/keyed_xor_cipher_if.sv
// Datapath/key bus for keyed_xor_cipher.
//   load_key : capture key on the next rising edge
//   key      : candidate key value
//   data_in  : plaintext or ciphertext
//   data_out : data_in ^ stored key (combinational)
// master drives key/data, slave is the cipher stage.
interface keyed_xor_cipher_if
  import xor_cipher_pkg::*;
#(
  parameter int WIDTH = XOR_DEFAULT_WIDTH
);

  logic             load_key;
  logic [WIDTH-1:0] key;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;

  modport master (
    output load_key,
    output key,
    output data_in,
    input  data_out
  );

  modport slave (
    input  load_key,
    input  key,
    input  data_in,
    output data_out
  );

endinterface

// File: rtl/keyed_xor_cipher_key_reg.sv
// xor_key_reg: WIDTH-bit key register, synchronous active-high reset,
// load enable. Reset wins over load.
//   clk, reset : clock, sync reset
//   load       : capture d on the rising edge
//   d          : value to capture
//   q          : stored key
module xor_key_reg
  import xor_cipher_pkg::*;
#(
  parameter int WIDTH = XOR_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)     q <= '0;
    else if (load) q <= d;
  end

endmodule

// File: rtl/keyed_xor_cipher.sv
// keyed_xor_cipher: zero-latency XOR transform stage. data_out is data_in
// XOR the stored key; the same block both encrypts and decrypts. A zero key
// (after reset) gives pass-through.
//   clk, reset : clock, synchronous active-high reset (clears the key)
//   bus        : slave side of keyed_xor_cipher_if (load_key, key,
//                data_in, data_out)
module keyed_xor_cipher
  import xor_cipher_pkg::*;
#(
  parameter int WIDTH = XOR_DEFAULT_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  keyed_xor_cipher_if.slave   bus
);

  logic [WIDTH-1:0] key_reg;

  xor_key_reg #(.WIDTH(WIDTH)) u_key_reg (
    .clk   (clk),
    .reset (reset),
    .load  (bus.load_key),
    .d     (bus.key),
    .q     (key_reg)
  );

  // Data path is purely combinational; key changes take effect right
  // after the loading edge.
  assign bus.data_out = bus.data_in ^ key_reg;

endmodule

// File: tb/tb_keyed_xor_cipher.sv
// Directed bench: encryptor feeding decryptor, both sharing key/load/reset.
module tb_keyed_xor_cipher;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         load_key;
  logic [W-1:0] key;
  logic [W-1:0] pt;

  int n_run  = 0;
  int n_fail = 0;

  keyed_xor_cipher_if #(.WIDTH(W)) enc_if ();
  keyed_xor_cipher_if #(.WIDTH(W)) dec_if ();

  assign enc_if.load_key = load_key;
  assign enc_if.key      = key;
  assign enc_if.data_in  = pt;
  assign dec_if.load_key = load_key;
  assign dec_if.key      = key;
  assign dec_if.data_in  = enc_if.data_out;

  keyed_xor_cipher #(.WIDTH(W)) u_enc (.clk(clk), .reset(reset), .bus(enc_if));
  keyed_xor_cipher #(.WIDTH(W)) u_dec (.clk(clk), .reset(reset), .bus(dec_if));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic do_load(input logic [W-1:0] k);
    key = k; load_key = 1'b1;
    @(posedge clk); #1;
    load_key = 1'b0;
  endtask

  task automatic scen(input string tag, input logic [W-1:0] k, input logic [W-1:0] p,
                      input logic [W-1:0] exp_ct);
    do_reset();
    do_load(k);
    pt = p; #1;
    chk({tag, "_ct"}, enc_if.data_out, exp_ct);
    chk({tag, "_pt"}, dec_if.data_out, p);
  endtask

  initial begin
    reset = 1'b1; load_key = 1'b0; key = '0; pt = '0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // Reset state: zero key, pass-through
    pt = 8'h96; #1;
    chk("rst_pass", enc_if.data_out, 8'h96);

    scen("b3_ca", 8'hB3, 8'hCA, 8'h79);
    scen("ac_41", 8'hAC, 8'h41, 8'hED);
    scen("00_ff", 8'h00, 8'hFF, 8'hFF);
    scen("b3_4f", 8'hB3, 8'h4F, 8'hFC);

    // Key changes without load_key have no effect
    do_reset();
    pt = 8'h5A; #1;
    chk("noload_a", enc_if.data_out, 8'h5A);
    key = 8'hFF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("noload_b", enc_if.data_out, 8'h5A);

    // Reset beats load in the same cycle
    key = 8'hC3; load_key = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; load_key = 1'b0;
    pt = 8'h3C; #1;
    chk("rst_over_ld", enc_if.data_out, 8'h3C);
    do_load(8'hC3);
    pt = 8'h3C; #1;
    chk("ld_c3", enc_if.data_out, 8'hFF);
    chk("ld_c3_dec", dec_if.data_out, 8'h3C);

    // Held load: last sampled key wins
    do_reset();
    key = 8'hA5; load_key = 1'b1;
    @(posedge clk); #1;
    key = 8'h0F;
    @(posedge clk); #1;
    load_key = 1'b0; key = 8'h77;
    pt = 8'hF0; #1;
    chk("held_last", enc_if.data_out, 8'hFF);

    // Combinational data path within the cycle
    pt = 8'h12; #1;
    chk("comb_data", enc_if.data_out, 8'h1D);

    // Mid-stream reset returns to pass-through
    reset = 1'b1;
    #1;
    chk("pre_rst_edge", enc_if.data_out, 8'h1D);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_rst", enc_if.data_out, 8'h12);
    chk("mid_rst_dec", dec_if.data_out, 8'h12);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
